// File: rtl/bch_correct.sv
// BCH correction stage: buffers received data bits in two ping-pong banks and
// XORs them with the Chien search error stream, counting corrected bits.
module bch_correct #(
  parameter int M = 4,
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_data,
  output logic         in_ready,
  input  logic         err_valid,
  input  logic         err,
  output logic         err_accepted,
  output logic         out_valid,
  output logic         out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [M-1:0] nerr,
  output logic         sync_err
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t        st     [2];
  bank_st_t        st_nxt [2];
  logic [K-1:0]    mem    [2];
  logic            wb;
  logic            rb;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic [M-1:0]    cnt;
  logic            sync_err_q;

  logic            wr;
  logic            wr_last;
  logic            rd;
  logic            rd_ok;
  logic            rd_last;

  // Handshake decode: everything below depends only on registered state plus
  // the current input strobes, so in_ready never combinationally sees in_valid.
  assign in_ready     = (st[wb] == EMPTY) || (st[wb] == FILLING);
  assign rd_ok        = (st[rb] == FULL) || (st[rb] == DRAINING);
  assign out_valid    = err_valid && rd_ok;
  assign out_data     = mem[rb][rd_idx] ^ err;
  assign out_last     = out_valid && (rd_idx == LAST_IDX);
  assign err_accepted = out_valid && out_ready;
  assign nerr         = out_last ? (cnt + M'(err)) : '0;
  assign sync_err     = sync_err_q;

  assign wr      = in_valid && in_ready;
  assign wr_last = wr && (wr_idx == LAST_IDX);
  assign rd      = err_accepted;
  assign rd_last = rd && out_last;

  // A write needs bank[wb] EMPTY/FILLING and a read needs bank[rb]
  // FULL/DRAINING, so both updates in one cycle always hit different banks.
  always_comb begin
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    if (wr) st_nxt[wb] = wr_last ? FULL : FILLING;
    if (rd) st_nxt[rb] = rd_last ? EMPTY : DRAINING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      cnt        <= '0;
      sync_err_q <= 1'b0;
    end else begin
      st[0] <= st_nxt[0];
      st[1] <= st_nxt[1];
      if (wr) begin
        if (wr_last) begin
          wr_idx <= '0;
          wb     <= ~wb;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (rd) begin
        if (rd_last) begin
          rd_idx <= '0;
          cnt    <= '0;
          rb     <= ~rb;
        end else begin
          rd_idx <= rd_idx + 1'b1;
          cnt    <= cnt + M'(err);
        end
      end
      if (err_valid && !rd_ok) sync_err_q <= 1'b1;
    end
  end

  // Bank storage carries no reset; the bank state alone decides validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wb][wr_idx] <= in_data;
  end

endmodule
